// File: rtl/hasti_dbg_cmd_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hasti_dbg_cmd_engine_pkg
// Purpose  : Opcodes, write-ack byte and FSM state encoding shared by the
//            debug-bridge command engine.
// Revision : 1.0  initial release
// ============================================================================
package hasti_dbg_cmd_engine_pkg;

  localparam logic [7:0] c_op_read  = 8'h01;
  localparam logic [7:0] c_op_write = 8'h02;
  localparam logic [7:0] c_wr_ack   = 8'hA5;

  localparam int c_state_w = 3;

  typedef enum logic [c_state_w-1:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_SEND  = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hasti_dbg_cmd_engine_rsp_serializer.sv
`default_nettype none
// ============================================================================
// Module   : hasti_dbg_cmd_engine_rsp_serializer
// Purpose  : Loads a response word plus byte count and emits it LSB byte
//            first over valid/ready; pulses o_done as the last byte leaves.
// Revision : 1.0  initial release
// ============================================================================
module hasti_dbg_cmd_engine_rsp_serializer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic [CNT_W-1:0]  i_count,
  output logic [7:0]        o_bits,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_done
);

  logic [DATA_W-1:0] r_word;
  logic [CNT_W-1:0]  r_left;
  logic              r_valid;

  logic w_fire;
  logic w_last;

  assign w_fire = r_valid & i_ready;
  assign w_last = (r_left == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_left  <= i_count;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      // Last byte keeps its value on o_bits; only valid drops.
      if (w_last) begin
        r_valid <= 1'b0;
      end else begin
        r_word <= r_word >> 8;
        r_left <= r_left - CNT_W'(1);
      end
    end
  end

  assign o_bits  = r_word[7:0];
  assign o_valid = r_valid;
  assign o_done  = w_fire & w_last;

endmodule
`default_nettype wire

// File: rtl/hasti_dbg_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : hasti_dbg_cmd_engine
// Purpose  : Byte-stream command engine: assembles opcode/address/data frames
//            into one HASTI command, waits for the response, serializes it.
// Revision : 1.0  initial release
// ============================================================================
module hasti_dbg_cmd_engine
  import hasti_dbg_cmd_engine_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_bits,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  output logic [7:0]        out_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int c_addr_bytes = ADDR_W / 8;
  localparam int c_data_bytes = DATA_W / 8;
  localparam int c_cnt_w      = $clog2(max_int(ADDR_W, DATA_W) / 8) + 1;
  localparam int c_ser_cnt_w  = $clog2(c_data_bytes) + 1;

  localparam logic [c_cnt_w-1:0] c_addr_last = c_cnt_w'(c_addr_bytes - 1);
  localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(c_data_bytes - 1);

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_cmd_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_cmd_valid;
  logic                r_rsp_ready;
  logic                r_in_ready;
  logic [ERR_W-1:0]    r_err_cnt;

  logic                   w_in_fire;
  logic                   w_cmd_fire;
  logic                   w_rsp_fire;
  logic                   w_op_read;
  logic                   w_op_write;
  logic                   w_ser_load;
  logic [DATA_W-1:0]      w_ser_word;
  logic [c_ser_cnt_w-1:0] w_ser_count;
  logic                   w_ser_done;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_cmd_fire = r_cmd_valid & cmd_ready;
  assign w_rsp_fire = r_rsp_ready & rsp_valid;
  assign w_op_read  = (in_bits == c_op_read);
  assign w_op_write = (in_bits == c_op_write);

  // The serializer captures the response on the same edge the FSM enters SEND.
  assign w_ser_load  = (r_state == ST_WAIT) & w_rsp_fire;
  assign w_ser_word  = r_cmd_write ? DATA_W'(c_wr_ack) : rsp_rdata;
  assign w_ser_count = r_cmd_write ? c_ser_cnt_w'(1) : c_ser_cnt_w'(c_data_bytes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cmd_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_in_ready  <= 1'b1;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            if (w_op_read || w_op_write) begin
              r_state     <= ST_ADDR;
              r_cnt       <= '0;
              r_cmd_write <= w_op_write;
              r_wdata     <= '0;
            end else if (r_err_cnt != '1) begin
              r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
          end
        end

        ST_ADDR: begin
          if (w_in_fire) begin
            for (int k = 0; k < c_addr_bytes; k++) begin
              if (r_cnt == c_cnt_w'(k)) r_addr[8*k +: 8] <= in_bits;
            end
            if (r_cnt == c_addr_last) begin
              r_cnt <= '0;
              if (r_cmd_write) begin
                r_state <= ST_DATA;
              end else begin
                r_state     <= ST_ISSUE;
                r_in_ready  <= 1'b0;
                r_cmd_valid <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
        end

        ST_DATA: begin
          if (w_in_fire) begin
            for (int k = 0; k < c_data_bytes; k++) begin
              if (r_cnt == c_cnt_w'(k)) r_wdata[8*k +: 8] <= in_bits;
            end
            if (r_cnt == c_data_last) begin
              r_cnt       <= '0;
              r_state     <= ST_ISSUE;
              r_in_ready  <= 1'b0;
              r_cmd_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
        end

        ST_ISSUE: begin
          if (w_cmd_fire) begin
            r_cmd_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
            r_state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (w_rsp_fire) begin
            r_rsp_ready <= 1'b0;
            r_state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (w_ser_done) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_cmd_valid <= 1'b0;
          r_rsp_ready <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  hasti_dbg_cmd_engine_rsp_serializer #(
    .DATA_W (DATA_W),
    .CNT_W  (c_ser_cnt_w)
  ) u_rsp_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ser_load),
    .i_word  (w_ser_word),
    .i_count (w_ser_count),
    .o_bits  (out_bits),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_done  (w_ser_done)
  );

  assign in_ready  = r_in_ready;
  assign cmd_write = r_cmd_write;
  assign cmd_addr  = r_addr;
  assign cmd_wdata = r_wdata;
  assign cmd_valid = r_cmd_valid;
  assign rsp_ready = r_rsp_ready;
  assign err_cnt   = r_err_cnt;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hasti_dbg_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_hasti_dbg_cmd_engine
// Purpose  : Scoreboard bench for the debug command engine.
// Revision : 1.0  initial release
// ============================================================================
module tb_hasti_dbg_cmd_engine;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        in_bits;
  logic              in_valid;
  logic              in_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        out_bits;
  logic              out_valid;
  logic              out_ready;
  logic [ERR_W-1:0]  err_cnt;
  logic              busy;

  always #5 clk = ~clk;

  hasti_dbg_cmd_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bits   (in_bits),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .out_bits  (out_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t              exp_cmd_q[$];
  logic [7:0]        exp_out_q[$];
  logic [DATA_W-1:0] rsp_q[$];

  int checks    = 0;
  int failures  = 0;
  int cmd_delay = 0;
  bit out_toggle = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_in_ready"},  in_ready,  1);
    check({pfx, "_cmd_valid"}, cmd_valid, 0);
    check({pfx, "_cmd_write"}, cmd_write, 0);
    check({pfx, "_cmd_addr"},  cmd_addr,  0);
    check({pfx, "_cmd_wdata"}, cmd_wdata, 0);
    check({pfx, "_rsp_ready"}, rsp_ready, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_bits"},  out_bits,  0);
    check({pfx, "_err_cnt"},   err_cnt,   0);
    check({pfx, "_busy"},      busy,      0);
  endtask

  // Each byte is presented until in_ready is seen off-edge, then one edge consumes it.
  task automatic send_bytes(input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) begin
      int n;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_bits  = bytes[i];
      n = 0;
      while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
      if (n >= 500) check("in_ready_timeout", 1, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata, input bit gaps);
    logic [7:0] f[$];
    cmd_t c;
    c.wr = 1'b0; c.addr = addr; c.wdata = '0;
    exp_cmd_q.push_back(c);
    rsp_q.push_back(rdata);
    for (int k = 0; k < DATA_W/8; k++) exp_out_q.push_back(rdata[8*k +: 8]);
    f.push_back(8'h01);
    for (int k = 0; k < ADDR_W/8; k++) f.push_back(addr[8*k +: 8]);
    send_bytes(f, gaps);
    check("rd_cmd_valid_first", cmd_valid, 1);
    check("rd_in_ready_issue", in_ready, 0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata, input bit gaps);
    logic [7:0] f[$];
    cmd_t c;
    c.wr = 1'b1; c.addr = addr; c.wdata = wdata;
    exp_cmd_q.push_back(c);
    rsp_q.push_back(DATA_W'($urandom));
    exp_out_q.push_back(8'hA5);
    f.push_back(8'h02);
    for (int k = 0; k < ADDR_W/8; k++) f.push_back(addr[8*k +: 8]);
    for (int k = 0; k < DATA_W/8; k++) f.push_back(wdata[8*k +: 8]);
    send_bytes(f, gaps);
    check("wr_cmd_valid_first", cmd_valid, 1);
    check("wr_in_ready_issue", in_ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_cmd_q.size() != 0 || exp_out_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("done_timeout", 1, 0);
  endtask

  // Command/response responder.
  initial begin : responder
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      cmd_ready = (cmd_delay == 0);
      if (rst_n && cmd_valid) begin
        int n;
        repeat (cmd_delay) begin @(posedge clk); #1; end
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = (cmd_delay == 0);
        rsp_rdata = (rsp_q.size() != 0) ? rsp_q.pop_front() : '0;
        rsp_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_ready && n < 100);
        if (n >= 100) check("rsp_ready_timeout", 1, 0);
        @(posedge clk); #1;
        rsp_valid = 1'b0;
      end
    end
  end

  initial begin : sink
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = out_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Handshakes are observed on the falling edge and complete on the next rising edge.
  initial begin : monitor
    logic              cmd_stall;
    logic              out_stall;
    logic              sv_write;
    logic [ADDR_W-1:0] sv_addr;
    logic [DATA_W-1:0] sv_wdata;
    logic [7:0]        sv_bits;
    cmd_stall = 1'b0;
    out_stall = 1'b0;
    sv_write = 1'b0; sv_addr = '0; sv_wdata = '0; sv_bits = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_stall = 1'b0;
        out_stall = 1'b0;
        continue;
      end
      if (cmd_stall) begin
        check("cmd_hold_valid", cmd_valid, 1);
        check("cmd_hold_write", cmd_write, sv_write);
        check("cmd_hold_addr",  cmd_addr,  sv_addr);
        check("cmd_hold_wdata", cmd_wdata, sv_wdata);
      end
      if (out_stall) begin
        check("out_hold_valid", out_valid, 1);
        check("out_hold_bits",  out_bits,  sv_bits);
      end
      if (cmd_valid || rsp_ready || out_valid) check("in_ready_blocked", in_ready, 0);
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          check("cmd_unexpected", 1, 0);
        end else begin
          cmd_t c;
          c = exp_cmd_q.pop_front();
          check("cmd_write", cmd_write, c.wr);
          check("cmd_addr",  cmd_addr,  c.addr);
          check("cmd_wdata", cmd_wdata, c.wdata);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) check("out_unexpected", 1, 0);
        else check("out_bits", out_bits, exp_out_q.pop_front());
      end
      cmd_stall = cmd_valid && !cmd_ready;
      out_stall = out_valid && !out_ready;
      sv_write = cmd_write; sv_addr = cmd_addr; sv_wdata = cmd_wdata; sv_bits = out_bits;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] f[$];
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bits  = 8'h00;
    #23;
    reset_checks("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. plain read
    do_read(32'h12345678, 32'hDEADBEEF, 1'b0);
    wait_done();
    // 2. plain write
    do_write(32'h80001000, 32'h11223344, 1'b0);
    wait_done();

    // 3. unknown opcodes saturate err_cnt
    f.delete();
    for (int i = 0; i < 10; i++) f.push_back((i % 2) ? 8'hFF : 8'h00);
    send_bytes(f, 1'b0);
    check("err_cnt_10", err_cnt, 10);
    check("err_busy_idle", busy, 0);
    f.delete();
    for (int i = 0; i < 290; i++) f.push_back((i % 2) ? 8'hFF : 8'h00);
    send_bytes(f, 1'b0);
    check("err_cnt_sat", err_cnt, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("err_no_cmd", cmd_valid, 0);

    // 4. backpressure on every interface
    cmd_delay  = 5;
    out_toggle = 1'b1;
    do_read(32'h12345678, 32'hDEADBEEF, 1'b1);
    wait_done();
    do_write(32'h80001000, 32'h11223344, 1'b1);
    wait_done();
    do_read(32'hA5A5_0F0F, 32'h0102_0304, 1'b1);
    wait_done();
    cmd_delay  = 0;
    out_toggle = 1'b0;

    // 5. back-to-back read then write, in_valid held high
    @(posedge clk); #1;
    do_read(32'h12345678, 32'hDEADBEEF, 1'b0);
    do_write(32'h80001000, 32'h11223344, 1'b0);
    wait_done();
    check("err_cnt_kept", err_cnt, 8'hFF);

    // 6. reset in the middle of a write's data bytes
    @(posedge clk); #1;
    f.delete();
    f = {8'h02, 8'h00, 8'h10, 8'h00, 8'h80, 8'h44, 8'h33};
    send_bytes(f, 1'b0);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(32'hCAFE_0004, 32'h5566_7788, 1'b0);
    wait_done();

    check("cmd_q_empty", exp_cmd_q.size(), 0);
    check("out_q_empty", exp_out_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
